// File: rtl/uci_response_formatter.sv
// UCI response formatter: serialises "bestmove <lan>\n" and "info depth <n>\n"
// lines from engine results onto a valid/ready byte stream, one ASCII byte per beat.
module uci_response_formatter #(
    parameter logic [7:0] NEWLINE = 8'h0A
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [5:0] move_from_in,
    input  logic [5:0] move_to_in,
    input  logic [2:0] move_promo_in,
    input  logic       move_null_in,
    input  logic       move_in_valid,
    output logic       move_in_ready,
    input  logic [7:0] depth_in,
    input  logic       depth_in_valid,
    output logic       depth_in_ready,
    output logic [7:0] char_out,
    output logic       char_out_valid,
    input  logic       char_out_ready,
    output logic       busy_out
);

    localparam logic [71:0] MovePrefix = "bestmove ";
    localparam logic [87:0] InfoPrefix = "info depth ";

    typedef enum logic [1:0] {StIdle, StMove, StInfo} state_e;

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic [7:0]  char_q, char_d;
    logic        valid_q, valid_d;
    logic [3:0]  idx_q, idx_d;      // index of the next byte to load into char_q
    logic [3:0]  len_q;             // total line length in bytes
    logic [7:0]  mv_q [5];          // bytes following "bestmove "
    logic [7:0]  dg_q [3];          // bytes following "info depth " (unused slots hold NEWLINE)

    logic [7:0]  mv_d [5];
    logic [3:0]  mv_len;
    logic [7:0]  dg_d [3];
    logic [3:0]  dg_len;
    logic [7:0]  next_char;
    logic        depth_acc, move_acc, beat_acc;

    logic [1:0]  hund;
    logic [3:0]  tens;
    logic [7:0]  rem, tens_sub, ones;

    // A pending depth report blocks the move handshake so the info line goes first.
    assign depth_in_ready = ready_q;
    assign move_in_ready  = ready_q & ~depth_in_valid;
    assign depth_acc      = depth_in_valid & depth_in_ready;
    assign move_acc       = move_in_valid & move_in_ready;
    assign beat_acc       = valid_q & char_out_ready;

    assign char_out       = char_q;
    assign char_out_valid = valid_q;
    assign busy_out       = (state_q != StIdle);

    // Decimal conversion of the depth by fixed compare/subtract steps.
    always_comb begin
        hund     = 2'd0;
        rem      = depth_in;
        tens     = 4'd0;
        tens_sub = 8'd0;
        if (depth_in >= 8'd200) begin
            hund = 2'd2;
            rem  = depth_in - 8'd200;
        end else if (depth_in >= 8'd100) begin
            hund = 2'd1;
            rem  = depth_in - 8'd100;
        end
        for (int k = 1; k < 10; k++) begin
            if (rem >= 8'(10 * k)) begin
                tens     = 4'(k);
                tens_sub = 8'(10 * k);
            end
        end
        ones = rem - tens_sub;
        if (hund != 2'd0) begin
            dg_d[0] = 8'h30 + {6'd0, hund};
            dg_d[1] = 8'h30 + {4'd0, tens};
            dg_d[2] = 8'h30 + ones;
            dg_len  = 4'd15;
        end else if (tens != 4'd0) begin
            dg_d[0] = 8'h30 + {4'd0, tens};
            dg_d[1] = 8'h30 + ones;
            dg_d[2] = NEWLINE;
            dg_len  = 4'd14;
        end else begin
            dg_d[0] = 8'h30 + ones;
            dg_d[1] = NEWLINE;
            dg_d[2] = NEWLINE;
            dg_len  = 4'd13;
        end
    end

    // Long-algebraic move text, precomputed at capture.
    always_comb begin
        mv_d[0] = 8'h61 + {5'd0, move_from_in[2:0]};
        mv_d[1] = 8'h31 + {5'd0, move_from_in[5:3]};
        mv_d[2] = 8'h61 + {5'd0, move_to_in[2:0]};
        mv_d[3] = 8'h31 + {5'd0, move_to_in[5:3]};
        mv_d[4] = NEWLINE;
        mv_len  = 4'd14;
        case (move_promo_in)
            3'd1: begin mv_d[4] = "n"; mv_len = 4'd15; end
            3'd2: begin mv_d[4] = "b"; mv_len = 4'd15; end
            3'd3: begin mv_d[4] = "r"; mv_len = 4'd15; end
            3'd4: begin mv_d[4] = "q"; mv_len = 4'd15; end
            default: ;
        endcase
        if (move_null_in) begin
            mv_d[0] = "0";
            mv_d[1] = "0";
            mv_d[2] = "0";
            mv_d[3] = "0";
            mv_d[4] = NEWLINE;
            mv_len  = 4'd14;
        end
    end

    // Byte at position idx_q of the line being emitted.
    always_comb begin
        next_char = NEWLINE;
        if (state_q == StMove) begin
            if (idx_q < 4'd9) begin
                next_char = MovePrefix[8 * (8 - int'(idx_q)) +: 8];
            end else begin
                case (idx_q)
                    4'd9:    next_char = mv_q[0];
                    4'd10:   next_char = mv_q[1];
                    4'd11:   next_char = mv_q[2];
                    4'd12:   next_char = mv_q[3];
                    4'd13:   next_char = mv_q[4];
                    default: next_char = NEWLINE;
                endcase
            end
        end else if (state_q == StInfo) begin
            if (idx_q < 4'd11) begin
                next_char = InfoPrefix[8 * (10 - int'(idx_q)) +: 8];
            end else begin
                case (idx_q)
                    4'd11:   next_char = dg_q[0];
                    4'd12:   next_char = dg_q[1];
                    4'd13:   next_char = dg_q[2];
                    default: next_char = NEWLINE;
                endcase
            end
        end
    end

    // Next-state: arbitration in idle, beat sequencing while emitting.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        char_d  = char_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (depth_acc) begin
                    state_d = StInfo;
                    char_d  = "i";
                    valid_d = 1'b1;
                    idx_d   = 4'd1;
                end else if (move_acc) begin
                    state_d = StMove;
                    char_d  = "b";
                    valid_d = 1'b1;
                    idx_d   = 4'd1;
                end
            end
            StMove, StInfo: begin
                if (beat_acc) begin
                    if (idx_q == len_q) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        idx_d   = 4'd0;
                    end else begin
                        char_d = next_char;
                        idx_d  = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
    end

    // State, output and captured-request registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            idx_q   <= 4'd0;
            len_q   <= 4'd0;
            mv_q    <= '{default: 8'h00};
            dg_q    <= '{default: 8'h00};
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            if (depth_acc) begin
                dg_q  <= dg_d;
                len_q <= dg_len;
            end else if (move_acc) begin
                mv_q  <= mv_d;
                len_q <= mv_len;
            end
        end
    end

endmodule

// File: tb/tb_uci_response_formatter.sv
// Self-checking bench for uci_response_formatter: directed scenarios plus randomized
// requests and backpressure, compared against expected text lines built with $sformatf.
module tb_uci_response_formatter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] move_from, move_to;
    logic [2:0] move_promo;
    logic       move_null, move_valid, depth_valid, out_ready;
    logic [7:0] depth;
    logic       move_ready, depth_ready, out_valid, busy;
    logic [7:0] out_char;

    int checks = 0;
    int errors = 0;
    byte exp_q[$];
    int  beats = 0;
    int  rdy_mode = 0;
    int  stall_cnt = 0;
    bit  stalled = 0;

    uci_response_formatter dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .move_from_in  (move_from),
        .move_to_in    (move_to),
        .move_promo_in (move_promo),
        .move_null_in  (move_null),
        .move_in_valid (move_valid),
        .move_in_ready (move_ready),
        .depth_in      (depth),
        .depth_in_valid(depth_valid),
        .depth_in_ready(depth_ready),
        .char_out      (out_char),
        .char_out_valid(out_valid),
        .char_out_ready(out_ready),
        .busy_out      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference text of each line.
    function automatic string move_str(int from, int to, int promo, bit nul);
        string p;
        if (nul) return "bestmove 0000\n";
        case (promo)
            1: p = "n";
            2: p = "b";
            3: p = "r";
            4: p = "q";
            default: p = "";
        endcase
        return $sformatf("bestmove %c%c%c%c%s\n", 8'(97 + from % 8), 8'(49 + from / 8),
                         8'(97 + to % 8), 8'(49 + to / 8), p);
    endfunction

    function automatic string info_str(int d);
        return $sformatf("info depth %0d\n", d);
    endfunction

    function automatic void push_str(string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endfunction

    // Downstream consumer: ready pattern chosen by rdy_mode.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (stall_cnt > 0) begin
                        out_ready = 1'b0;
                        stall_cnt--;
                    end else if (!stalled && beats >= 3) begin
                        stalled   = 1;
                        stall_cnt = 4;
                        out_ready = 1'b0;
                    end else begin
                        out_ready = ~out_ready;
                    end
                end
            endcase
        end
    end

    // Stream monitor: every accepted beat must match the next expected byte.
    initial begin
        bit  stall_pend = 0;
        byte stall_char = 0;
        byte e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_pend) begin
                    check_eq("stall_data_stable", out_char, stall_char);
                    check_eq("stall_valid_held", out_valid, 1);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_beat", out_char, 32'h1ff);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("beat_char", out_char, e);
                        beats++;
                    end
                end
                stall_pend = out_valid && !out_ready;
                stall_char = out_char;
            end else begin
                stall_pend = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_move(input int from, input int to, input int promo, input bit nul);
        int n = 0;
        string s = move_str(from, to, promo, nul);
        move_from = 6'(from); move_to = 6'(to); move_promo = 3'(promo); move_null = nul;
        move_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (move_ready) break;
            if (++n > 300) begin
                check_eq("move_accept_timeout", move_ready, 1);
                move_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        push_str(s);
        #1;
        move_valid = 1'b0;
        move_from = 6'($urandom); move_to = 6'($urandom);
        move_promo = 3'($urandom); move_null = 1'($urandom);
        check_eq("move_first_valid", out_valid, 1);
        check_eq("move_first_char", out_char, s[0]);
        check_eq("move_busy", busy, 1);
        check_eq("move_ready_low", move_ready, 0);
        check_eq("depth_ready_low_m", depth_ready, 0);
    endtask

    task automatic send_depth(input int d);
        int n = 0;
        string s = info_str(d);
        depth = 8'(d);
        depth_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (depth_ready) break;
            if (++n > 300) begin
                check_eq("depth_accept_timeout", depth_ready, 1);
                depth_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        push_str(s);
        #1;
        depth_valid = 1'b0;
        depth = 8'($urandom);
        check_eq("info_first_valid", out_valid, 1);
        check_eq("info_first_char", out_char, s[0]);
        check_eq("info_busy", busy, 1);
        check_eq("depth_ready_low", depth_ready, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("line_drained", exp_q.size(), 0);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_move_ready", move_ready, 1);
        check_eq("idle_depth_ready", depth_ready, 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        move_from = '0; move_to = '0; move_promo = '0; move_null = 0; move_valid = 0;
        depth = '0; depth_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_char", out_char, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_move_ready", move_ready, 1);
        check_eq("rst_depth_ready", depth_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Quiet move with exact timing of the end of line.
        send_move(12, 28, 0, 0);
        repeat (13) @(posedge clk);
        #1;
        check_eq("e2e4_busy_before_nl", busy, 1);
        @(posedge clk);
        #1;
        check_eq("e2e4_busy_after_nl", busy, 0);
        check_eq("e2e4_ready_after_nl", move_ready, 1);
        wait_idle();

        send_move(52, 60, 4, 0); wait_idle();
        send_move(52, 60, 6, 0); wait_idle();
        send_move(52, 60, 0, 1); wait_idle();
        send_depth(0);   wait_idle();
        send_depth(7);   wait_idle();
        send_depth(105); wait_idle();
        send_depth(255); wait_idle();

        // Backpressure: alternate ready with a 5-cycle stall after beat 3.
        beats = 0; stalled = 0; stall_cnt = 0; rdy_mode = 2;
        send_move(6, 21, 0, 0);
        wait_idle();
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Simultaneous requests: info line goes first.
        move_from = 6'd12; move_to = 6'd28; move_promo = 3'd0; move_null = 0; move_valid = 1;
        depth = 8'd3; depth_valid = 1;
        @(negedge clk);
        check_eq("simul_move_ready", move_ready, 0);
        check_eq("simul_depth_ready", depth_ready, 1);
        @(posedge clk);
        push_str(info_str(3));
        #1;
        depth_valid = 0;
        depth = 8'($urandom);
        n = 0;
        forever begin
            @(negedge clk);
            if (move_ready || n > 300) break;
            n++;
        end
        check_eq("simul_info_done_first", exp_q.size(), 0);
        check_eq("simul_move_ready_late", move_ready, 1);
        @(posedge clk);
        push_str(move_str(12, 28, 0, 0));
        #1;
        move_valid = 0;
        wait_idle();

        // Reset during beat 5 of a move line.
        send_move(12, 28, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_move_ready", move_ready, 1);
        check_eq("midrst_depth_ready", depth_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("midrst_no_residual", out_valid, 0);
        end
        send_depth(9);
        wait_idle();

        // Randomized requests with random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                send_depth(int'($urandom_range(0, 255)));
            end else begin
                send_move(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                          int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
            end
            wait_idle();
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uci_response_formatter.md
Name: uci_response_formatter

Overview:
- Transmit-side counterpart to the UCI command parser: converts engine results into UCI text lines on a byte stream toward the UART/host.
- Accepts a best move (square indices plus promotion) and a search-depth report, each through its own valid/ready handshake.
- Serialises "bestmove <lan>\n" and "info depth <n>\n" one ASCII character per accepted beat.

Parameters:
- NEWLINE, 8'h0A: line terminator byte appended to every line.

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_in  input  1  reset, synchronous and active-low: all state clears on the rising clk_in edge where rst_in==0.
- move_from_in  input  6  source square, sq = rank*8 + file; file 0 = 'a', rank 0 = '1'.
- move_to_in  input  6  destination square, same encoding.
- move_promo_in  input  3  0 none, 1 n, 2 b, 3 r, 4 q; 5..7 are treated as none.
- move_null_in  input  1  no legal move; emit "0000".
- move_in_valid  input  1  move fields valid.
- move_in_ready  output  1  formatter accepts a move this cycle.
- depth_in  input  8  search depth, unsigned 0..255.
- depth_in_valid  input  1  depth report valid.
- depth_in_ready  output  1  formatter accepts a depth this cycle.
- char_out  output  8  ASCII byte.
- char_out_valid  output  1  char_out holds a valid byte.
- char_out_ready  input  1  downstream consumes the byte.
- busy_out  output  1  a line is being emitted.

Behaviour:
- Reset (rst_in==0 at an edge):
  - state = IDLE; char_out = 0, char_out_valid = 0, busy_out = 0.
  - move_in_ready = 1 and depth_in_ready = 1 from the first cycle after reset.
- Ready outputs: registered, high only in IDLE.
- Arbitration in IDLE:
  - Accept on valid && ready.
  - If both inputs are valid in the same cycle, only depth is accepted (info precedes bestmove); move_in_ready is deasserted that cycle. The move is held by its source and accepted after the info line.
- Capture: accepted fields are latched internally, so inputs may change after the handshake.
- Latency: first character is valid on the cycle after acceptance, i.e. char_out_valid rises one edge after the handshake edge.
- States:
  - IDLE -> EMIT_MOVE on move accept; IDLE -> EMIT_INFO on depth accept.
  - EMIT_* -> IDLE after the NEWLINE byte is accepted.
  - Readiness for a new request returns on the cycle after the last byte is accepted; there is no back-to-back overlap.
- Output stream (valid/ready):
  - char_out and char_out_valid are registered.
  - Once valid is high, char_out stays stable and valid stays high until the cycle char_out_ready==1.
  - Beat index advances only on an accepted beat.
  - One byte per cycle when ready is held high.
- Move line:
  - "bestmove " (9 bytes), then file char ('a'+sq[2:0]) and rank char ('1'+sq[5:3]) for from, then the same for to.
  - Then the promo letter if move_promo_in is 1..4, then NEWLINE.
  - Lengths: 14 bytes, or 15 with promotion.
  - move_null_in=1: "bestmove 0000\n" (14 bytes); squares and promo ignored.
- Info line:
  - "info depth " (11 bytes), then decimal depth, then NEWLINE.
  - Digits are computed at capture by a fixed subtract/compare of hundreds and tens (no divider). No leading zeros; depth 0 emits "0".
  - Lengths: 13 / 14 / 15 bytes for 1 / 2 / 3 digits.
- busy_out: high from the cycle after acceptance through the cycle the NEWLINE byte is accepted.
- Reset mid-line: line aborted immediately, no further bytes emitted, outputs at reset values on the next cycle; the latched request is discarded.
- Downstream stalls: char_out_ready held 0 indefinitely freezes the beat; no timeout.

Test Plan:
- Quiet move: from=12, to=28, promo=0, null=0, char_out_ready=1.
  -> "bestmove e2e4\n", 14 consecutive beats; first beat one cycle after acceptance; move_in_ready back high after the '\n' beat.
- Promotion and null:
  - from=52, to=60, promo=4 -> "bestmove e7e8q\n" (15 bytes).
  - promo=6 -> "bestmove e7e8\n".
  - null=1 -> "bestmove 0000\n".
- Depth decimal: depth 0, 7, 105, 255.
  -> "info depth 0\n", "info depth 7\n", "info depth 105\n", "info depth 255\n".
- Backpressure: from=6 (g1), to=21 (f3); char_out_ready low on alternate cycles and low for 5 cycles after beat 3.
  -> same byte sequence with no drops or duplicates; char_out stable while valid && !ready.
- Simultaneous requests: move (e2e4) and depth 3 both valid in the same cycle.
  -> "info depth 3\n" then "bestmove e2e4\n"; move_in_ready stays 0 until the info line completes.
- Reset mid-line: rst_in=0 for one cycle during beat 5 of a move line.
  -> char_out_valid=0 and busy_out=0 on the next cycle, both readies=1, no residual bytes; a new depth=9 request then yields "info depth 9\n".
